// File: rtl/pr_encoder_q.sv
// pr_encoder_q
//   Registered priority encoder with request latching and a valid/ack
//   output handshake. Request pulses on data_in are collected into a pending
//   register; one index at a time is presented on y_out and held until the
//   consumer acknowledges it.
//
//   Build option: define PR_ENC_RR_EN for round-robin arbitration (a pointer
//   remembers the last loaded index and the search restarts just below it).
//   Left undefined, the highest set index always wins.
//
//   Ports
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     data_in      request pulses, one bit per source
//     clear        synchronous clear of pending, ovf and the held output
//     ack_in       consumer accepts y_out (ignored while valid_out = 0)
//     y_out        index of the presented request
//     valid_out    y_out holds a live request
//     pending_out  pending requests, excluding the presented index
//     ovf          sticky overrun flag
//
//   Slot states
//     IDLE | valid_out = 0, next non-empty pend_eff is loaded
//     HOLD | valid_out = 1, y_out frozen until ack_in
module pr_encoder_q #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] data_in,
  input  logic         clear,
  input  logic         ack_in,
  output logic [W-1:0] y_out,
  output logic         valid_out,
  output logic [N-1:0] pending_out,
  output logic         ovf
);

  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] y_q, y_d;
  logic         valid_q, valid_d;
  logic         ovf_q, ovf_d;

  logic [N-1:0] pend_eff;
  logic [N-1:0] win_oh;
  logic [N-1:0] held_oh;
  logic [W-1:0] win_idx;
  logic         win_found;
  logic         hold;
  logic         hold_hit;
  logic         ovf_set;

`ifdef PR_ENC_RR_EN
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] cand;
`endif

  // Winner search over pend_eff.
  always_comb begin
    pend_eff  = pend_q | data_in;
    win_found = 1'b0;
    win_idx   = '0;
`ifdef PR_ENC_RR_EN
    cand      = '0;
    // Descending from (ptr-1) mod N, wrapping below 0 to N-1; ptr itself last.
    for (int k = 1; k <= N; k++) begin
      cand = W'((int'(ptr_q) + N - k) % N);
      if (!win_found && pend_eff[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`else
    // Ascending scan, so the last (highest) set index overwrites earlier ones.
    for (int i = 0; i < N; i++) begin
      if (pend_eff[i]) begin
        win_found = 1'b1;
        win_idx   = W'(i);
      end
    end
`endif
  end

  always_comb begin
    win_oh   = N'(1) << win_idx;
    held_oh  = N'(1) << y_q;
    hold     = valid_q & ~ack_in;
    // A repeat request for the index being held is an overrun and is dropped,
    // so the same index is never presented twice for one burst.
    hold_hit = hold & data_in[y_q];

    pend_d  = pend_q;
    y_d     = y_q;
    valid_d = valid_q;
    ovf_set = 1'b0;
`ifdef PR_ENC_RR_EN
    ptr_d   = ptr_q;
`endif

    if (clear) begin
      pend_d  = '0;
      y_d     = '0;
      valid_d = 1'b0;
`ifdef PR_ENC_RR_EN
      ptr_d   = '0;
`endif
    end else if (hold) begin
      ovf_set = (|(data_in & pend_q)) | hold_hit;
      pend_d  = pend_eff & ~(hold_hit ? held_oh : '0);
    end else if (win_found) begin
      // A new pulse on the winner is absorbed into this load, not an overrun.
      ovf_set = |(data_in & pend_q & ~win_oh);
      pend_d  = pend_eff & ~win_oh;
      y_d     = win_idx;
      valid_d = 1'b1;
`ifdef PR_ENC_RR_EN
      ptr_d   = win_idx;
`endif
    end else begin
      pend_d  = pend_eff;
      valid_d = 1'b0;
    end

    ovf_d = clear ? 1'b0 : (ovf_q | ovf_set);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef PR_ENC_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      pend_q  <= pend_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
`ifdef PR_ENC_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign y_out       = y_q;
  assign valid_out   = valid_q;
  assign pending_out = pend_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_pr_encoder_q.sv
module tb_pr_encoder_q;
  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] data_in;
  logic         clear;
  logic         ack_in;
  logic [W-1:0] y_out;
  logic         valid_out;
  logic [N-1:0] pending_out;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  pr_encoder_q #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .clear(clear),
    .ack_in(ack_in), .y_out(y_out), .valid_out(valid_out),
    .pending_out(pending_out), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a set of waiting requests, the presented request, a
  // sticky overrun flag and the last index handed out.
  bit m_wait [N];
  int m_y;
  bit m_valid;
  bit m_ovf;
  int m_last;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_wait[i] = 0;
    m_y = 0; m_valid = 0; m_ovf = 0; m_last = 0;
  endtask

  // Which waiting request is served next.
  function automatic int choose(input bit cand [N]);
`ifdef PR_ENC_RR_EN
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last - k + N) % N;
      if (cand[idx]) return idx;
    end
`else
    for (int i = N - 1; i >= 0; i--) if (cand[i]) return i;
`endif
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] din, input bit clr, input bit ack);
    bit all [N];
    int w;
    if (clr) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) all[i] = m_wait[i] || din[i];
    if (m_valid && !ack) begin
      for (int i = 0; i < N; i++) if (din[i] && m_wait[i]) m_ovf = 1;
      if (din[m_y]) begin
        m_ovf = 1;
        all[m_y] = 0;
      end
      m_wait = all;
    end else begin
      w = choose(all);
      if (w >= 0) begin
        for (int i = 0; i < N; i++) if (din[i] && m_wait[i] && i != w) m_ovf = 1;
        all[w] = 0;
        m_y = w; m_valid = 1; m_last = w;
      end else begin
        m_valid = 0;
      end
      m_wait = all;
    end
  endtask

  function automatic logic [N-1:0] model_pending();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_wait[i];
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},   32'(valid_out),   32'(m_valid));
    check({tag, ".y"},       32'(y_out),       32'(m_y));
    check({tag, ".pending"}, 32'(pending_out), 32'(model_pending()));
    check({tag, ".ovf"},     32'(ovf),         32'(m_ovf));
  endtask

  // Apply inputs for one cycle, advance the model at the edge, check after it.
  task automatic cycle(input string tag, input logic [N-1:0] din, input bit clr, input bit ack);
    data_in = din; clear = clr; ack_in = ack;
    @(posedge clk);
    model_step(din, clr, ack);
    #1;
    check_all(tag);
    @(negedge clk);
    data_in = '0; clear = 1'b0; ack_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; data_in = '0; clear = 1'b0; ack_in = 1'b0;
    model_reset();
    #12;
    check_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-HOLD
    cycle("rst_load", 8'b0010_0000, 0, 0);
    check("rst_load.y5", 32'(y_out), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle("rst_idle", '0, 0, 0);

    // Single request held for 5 cycles, then acked
    cycle("single", 8'b0010_0000, 0, 0);
    check("single.y", 32'(y_out), 32'd5);
    for (int i = 0; i < 5; i++) cycle("single_hold", '0, 0, 0);
    cycle("single_ack", '0, 0, 1);
    check("single_ack.valid", 32'(valid_out), 32'd0);

    // Fixed priority drain with ack held high
    cycle("drain0", 8'b0100_0001, 0, 1);
    check("drain0.y", 32'(y_out), 32'd6);
    cycle("drain1", '0, 0, 1);
    check("drain1.y", 32'(y_out), 32'd0);
    cycle("drain2", '0, 0, 1);
    check("drain2.valid", 32'(valid_out), 32'd0);
    check("drain2.pending", 32'(pending_out), 32'd0);

    // Overrun on a held index, then clear
    cycle("ovf0", 8'b0000_1000, 0, 0);
    cycle("ovf1", 8'b0000_1000, 0, 0);
    check("ovf1.ovf", 32'(ovf), 32'd1);
    cycle("ovf_ack", '0, 0, 1);
    check("ovf_ack.single3", 32'(valid_out), 32'd0);
    cycle("ovf_clr", '0, 1, 0);
    check("ovf_clr.ovf", 32'(ovf), 32'd0);

    // Continuous requests on indices 7 and 1 with ack held
    begin
      int exp_y [4];
`ifdef PR_ENC_RR_EN
      exp_y = '{7, 1, 7, 1};
`else
      exp_y = '{7, 7, 7, 7};
`endif
      for (int i = 0; i < 4; i++) begin
        cycle("rr", 8'b1000_0010, 0, 1);
        check("rr.y", 32'(y_out), 32'(exp_y[i]));
`ifdef PR_ENC_RR_EN
        check("rr.ovf", 32'(ovf), 32'd0);
`endif
      end
    end
    cycle("rr_clr", '0, 1, 0);

    // Clear beats a simultaneous load and ack
    cycle("cl_setup", 8'b0001_0001, 0, 0);
    cycle("cl", 8'b0000_0100, 1, 1);
    check("cl.valid", 32'(valid_out), 32'd0);
    check("cl.pending", 32'(pending_out), 32'd0);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [N-1:0] d;
      d = N'($urandom & $urandom & $urandom);
      cycle("rand", d, ($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pr_encoder_q.md
# pr_encoder_q

Parametrised, registered priority encoder with request latching and a valid/ack output handshake. Single-cycle request pulses on `data_in` are captured into a pending register. One request at a time is presented as a binary index on `y_out`, and is held stable until the consumer acknowledges it. It is the sequential successor to the combinational 8:3 priority encoder and sits between interrupt/event sources and a single serialising consumer.

## Interface

**Parameters**
- `N`, default 8: number of request lines; N ≥ 2.
- `W`, default `$clog2(N)`: index width. This is a localparam derived from N and is not overridable.

**Ports**
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `data_in` input N: request pulses. Any bit high on a rising edge is a new request for that index.
- `clear` input 1: synchronous clear of the pending register, `ovf` and the held output.
- `ack_in` input 1: consumer accepts the current `y_out`. Meaningful only while `valid_out` is 1.
- `y_out` output W: index of the presented request.
- `valid_out` output 1: `y_out` holds a live request.
- `pending_out` output N: current pending register, excluding the presented index.
- `ovf` output 1: sticky overrun flag.

## Operation

**Reset**
- Reset is asynchronous and active-low (`rst_n` low). Reset values: `y_out`=0, `valid_out`=0, `pending_out`=0, `ovf`=0, rotate pointer=0.
- Reset takes effect immediately, including mid-handshake. A held request is lost.

**Request capture**
- `pend_eff = pending | data_in`, evaluated every cycle.
- A bit stays pending until it is loaded into the output register.

**Output register, two states**
- HOLD (`valid_out`=1, no `ack_in`): `y_out` is frozen and there is no re-arbitration.
- LOAD: the slot is free, i.e. `valid_out`=0, or `valid_out`=1 with `ack_in`=1. Then:
  - If `pend_eff` ≠ 0, the winner index is written to `y_out`, `valid_out` becomes 1, and the winner's bit is cleared from pending.
  - If `pend_eff` = 0, `valid_out` becomes 0 and `y_out` keeps its last value.
- Transitions:
  - IDLE→HOLD on a load.
  - HOLD→HOLD on `ack_in` with another pending bit (back-to-back loads).
  - HOLD→IDLE on `ack_in` with nothing pending.

**Priority**
- Fixed priority: the highest set index wins, so bit N-1 has the highest priority.

**Overrun**
- `ovf` is set when a `data_in` bit arrives while the same bit is already pending.
- `ovf` is also set when a `data_in` bit arrives for the index currently held in HOLD with no `ack_in` that cycle.
- Merged requests are not counted. `ovf` stays set until `clear` or reset.

**Clear**
- `clear`=1 forces pending=0, `valid_out`=0, `ovf`=0 and pointer=0.
- `data_in` in the same cycle as `clear` is discarded.
- `clear` has priority over `ack_in` and load.

**Simultaneous events**
- If a `data_in` bit equals the winner being loaded that cycle, it is absorbed into the load. It does not re-pend and does not set `ovf`.
- An `ack_in` while `valid_out`=0 is ignored.

## Timing

- Latency: a request sampled at edge k with the slot free gives `valid_out`=1 and `y_out`=index after edge k. That is one cycle from the request to the registered output.
- Throughput: one index per cycle when `ack_in` is held high and requests are pending.
- All outputs are registered with no combinational path from input to output.
- `y_out` and `valid_out` are stable from one edge to the next. The consumer samples them on the same edge at which it drives `ack_in`.

## Configuration

Macro: `PR_ENC_RR_EN`.

**When defined: round-robin arbitration**
- A W-bit pointer stores the last loaded index L.
- The search is descending, starting at (L-1) mod N and wrapping from 0 to N-1.
- The pointer resets to 0, so the first search starts at N-1 and matches fixed priority.
- The pointer updates only on a load.

**When undefined: fixed priority**
- No pointer register is built.
- Behaviour is fixed highest-index priority as described under Operation.

## Test plan

All scenarios use N=8.

1. **Reset.** Drive `rst_n`=0 mid-HOLD with `y_out`=5 → all outputs go to 0 immediately, before the next edge. After release, `valid_out` stays 0 while idle.
2. **Single request.** Pulse `data_in`=00100000 for one cycle with `ack_in`=0 → `valid_out`=1 and `y_out`=101 after that edge. Both hold for 5 cycles. Assert `ack_in` for one cycle → `valid_out`=0 on the next edge.
3. **Fixed priority drain.** Pulse `data_in`=01000001 and hold `ack_in`=1 → `y_out`=110 then `y_out`=000 on consecutive cycles, then `valid_out`=0, with `pending_out`=0.
4. **Overrun.**
   - Pulse 00001000, then pulse 00001000 again while it is held → `ovf`=1, and only one index 3 is presented.
   - Pulse `clear` → `ovf`=0 and `valid_out`=0.
5. **Round-robin (`PR_ENC_RR_EN`).** Keep `data_in`=10000010 asserted every cycle with `ack_in`=1 → `y_out` alternates 111, 001, 111, 001, and `ovf` stays 0 while each bit is absorbed at its load. Without the macro → `y_out` is constant 111.
6. **Clear vs load.** Drive `clear`=1 together with `data_in`=00000100 and `ack_in`=1 → after the edge, `valid_out`=0 and `pending_out`=0.
